imuldiv_muldiv_perf_monitor: RTL
================================

// Module: imuldiv_muldiv_perf_monitor
//
// PURPOSE
// Synthesizable, parametrised successor to the single-shot muldiv cycle-count harness.
// Sits inline between a muldiv request source/response sink and any imuldiv unit
// (iterative or pipelined). Forwards val/rdy traffic transparently and timestamps every
// transaction. Keeps running latency statistics and an error flag, for benches and for
// on-chip profiling.
//
// PARAMETERS
// W            32  operand width; result width is 2*W ({rem,quo} or full product)
// MAX_INFLIGHT 4   timestamp FIFO depth = max outstanding requests (power of 2, >=1)
// CNT_W        32  width of cycle counter, timestamps and all statistic counters
//
// PORTS
// clk              in   1        clock, all state on posedge
// reset            in   1        asynchronous, active-low reset (asserted when 0)
// clear            in   1        sync clear of statistics and error flag
// req_msg_fn       in   3        muldiv function code (MUL/DIV/DIVU/REM/REMU)
// req_msg_a        in   W        operand A
// req_msg_b        in   W        operand B
// req_val          in   1        upstream request valid
// req_rdy          out  1        upstream request ready
// dut_req_msg_fn   out  3        = req_msg_fn
// dut_req_msg_a    out  W        = req_msg_a
// dut_req_msg_b    out  W        = req_msg_b
// dut_req_val      out  1        req_val && !fifo_full
// dut_req_rdy      in   1        muldiv unit request ready
// dut_resp_result  in   2W       muldiv unit result
// dut_resp_val     in   1        muldiv unit response valid
// dut_resp_rdy     out  1        = resp_rdy
// resp_result      out  2W       = dut_resp_result
// resp_val         out  1        = dut_resp_val
// resp_rdy         in   1        downstream sink ready
// stat_txn_count   out  CNT_W    completed transactions (saturating)
// stat_lat_total   out  CNT_W    sum of latencies (saturating)
// stat_lat_min     out  CNT_W    minimum latency seen
// stat_lat_max     out  CNT_W    maximum latency seen
// stat_inflight    out  clog2(MAX_INFLIGHT)+1  current FIFO occupancy
// err_underflow    out  1        sticky: response with no outstanding request
//
// BEHAVIOUR
// - Reset (reset==0, async): cycle counter, FIFO pointers, count, total, max, inflight
//   and err_underflow go to 0; stat_lat_min goes to all-ones.
// - Passthrough paths are purely combinational, with zero added latency.
// - req_rdy = dut_req_rdy && !fifo_full. When full, the request path stalls and nothing
//   is dropped.
// - req_go  = req_val && req_rdy.  resp_go = dut_resp_val && resp_rdy.
// - Free-running cycle counter cyc increments every cycle and wraps mod 2^CNT_W.
// - On req_go: push cyc into the timestamp FIFO (in order).
// - On resp_go with occupancy>0: pop head ts. lat = (cyc - ts) mod 2^CNT_W.
//   - lat is the number of edges from the request edge to the response edge.
//   - The result is exact across counter wrap provided lat < 2^CNT_W.
// - Zero-latency bypass: req_go and resp_go in the same cycle with an empty FIFO gives
//   lat = 0, no push and no pop; occupancy stays 0.
// - Simultaneous push and pop with a non-empty FIFO: both happen and occupancy is unchanged.
// - Pop is allowed when full; a push while full cannot occur because req_rdy is 0.
// - Stats update on every counted completion. All stats are registered and visible the
//   cycle after resp_go.
//   - count += 1 and total += lat; both saturate at all-ones with no wrap.
//   - min = min(min, lat); max = max(max, lat).
// - Underflow: resp_go with empty FIFO and no same-cycle req_go:
//   - set err_underflow (sticky);
//   - stats unchanged; response still forwarded.
// - clear (sync) zeroes count, total, max and err_underflow, and sets min to all-ones.
//   - It does NOT touch the FIFO or cyc; outstanding requests keep their timestamps.
//   - clear wins over a same-cycle completion: that completion pops but is not counted.
// - No state machine beyond the FIFO; behaviour is identical for all fn codes.
//
// TESTING
// - Reset: hold reset=0 with req_val=1 -> stat_*=0, min=0xFFFFFFFF, err=0, req_rdy follows
//   dut_req_rdy.
// - Single op: 32-cycle DUT, one MUL 0x3*0x5 -> resp_result 0xF, count=1, min=max=total=32.
// - Back-pressure: MAX_INFLIGHT=4, DUT accepts 5 requests, no responses -> 5th stalls,
//   req_rdy=0, inflight=4; one response -> req_rdy=1.
// - Mixed latencies: 3 ops with latencies 1, 34, 7 -> count=3, total=42, min=1, max=34.
// - Counter wrap (CNT_W=8): request at cyc=250, response at cyc=4 -> lat=10.
// - Error and clear: response with nothing outstanding -> err_underflow=1, stats unchanged;
//   clear -> err=0, min=0xFFFFFFFF, inflight preserved.

Source files
------------

// File: rtl/imuldiv_muldiv_perf_monitor.sv
`default_nettype none
// ============================================================================
// Module   : imuldiv_muldiv_perf_monitor
// Purpose  : Inline val/rdy monitor placed between a muldiv request source /
//            response sink and an imuldiv unit. Forwards all traffic with no
//            added latency, timestamps each accepted request in an in-order
//            FIFO and keeps saturating latency statistics plus a sticky
//            underflow flag.
// Ports    : clk, reset (async, active-low), clear (sync stats clear)
//            req_*        upstream request side (msg, val, rdy)
//            dut_req_*    request side toward the muldiv unit
//            dut_resp_*   response side from the muldiv unit
//            resp_*       downstream response side
//            stat_*       latency statistics and FIFO occupancy
//            err_underflow sticky: response seen with nothing outstanding
// Revision : 1.0  initial release
// ============================================================================
module imuldiv_muldiv_perf_monitor #(
    parameter int W            = 32,
    parameter int MAX_INFLIGHT = 4,
    parameter int CNT_W        = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            clear,
    input  logic [2:0]                      req_msg_fn,
    input  logic [W-1:0]                    req_msg_a,
    input  logic [W-1:0]                    req_msg_b,
    input  logic                            req_val,
    output logic                            req_rdy,
    output logic [2:0]                      dut_req_msg_fn,
    output logic [W-1:0]                    dut_req_msg_a,
    output logic [W-1:0]                    dut_req_msg_b,
    output logic                            dut_req_val,
    input  logic                            dut_req_rdy,
    input  logic [2*W-1:0]                  dut_resp_result,
    input  logic                            dut_resp_val,
    output logic                            dut_resp_rdy,
    output logic [2*W-1:0]                  resp_result,
    output logic                            resp_val,
    input  logic                            resp_rdy,
    output logic [CNT_W-1:0]                stat_txn_count,
    output logic [CNT_W-1:0]                stat_lat_total,
    output logic [CNT_W-1:0]                stat_lat_min,
    output logic [CNT_W-1:0]                stat_lat_max,
    output logic [$clog2(MAX_INFLIGHT):0]   stat_inflight,
    output logic                            err_underflow
);

    // A depth-1 FIFO still needs a 1-bit pointer; it simply never leaves 0.
    localparam int c_ptr_w = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
    localparam int c_occ_w = $clog2(MAX_INFLIGHT) + 1;
    localparam logic [CNT_W-1:0]   c_cnt_ones = '1;
    localparam logic [c_occ_w-1:0] c_occ_full = c_occ_w'(MAX_INFLIGHT);
    localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(MAX_INFLIGHT - 1);

    logic [CNT_W-1:0]   r_cyc;
    logic [CNT_W-1:0]   r_ts_mem [MAX_INFLIGHT];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_occ_w-1:0] r_occ;
    logic [CNT_W-1:0]   r_txn_count;
    logic [CNT_W-1:0]   r_lat_total;
    logic [CNT_W-1:0]   r_lat_min;
    logic [CNT_W-1:0]   r_lat_max;
    logic               r_err;

    logic               w_full;
    logic               w_empty;
    logic               w_req_go;
    logic               w_resp_go;
    logic               w_bypass;
    logic               w_push;
    logic               w_pop;
    logic               w_complete;
    logic               w_underflow;
    logic [CNT_W-1:0]   w_lat;
    logic [CNT_W:0]     w_total_sum;

    // ---------------- transparent forwarding ----------------
    assign w_full          = (r_occ == c_occ_full);
    assign w_empty         = (r_occ == '0);
    assign req_rdy         = dut_req_rdy && !w_full;
    assign dut_req_val     = req_val && !w_full;
    assign dut_req_msg_fn  = req_msg_fn;
    assign dut_req_msg_a   = req_msg_a;
    assign dut_req_msg_b   = req_msg_b;
    assign dut_resp_rdy    = resp_rdy;
    assign resp_result     = dut_resp_result;
    assign resp_val        = dut_resp_val;

    // ---------------- transaction bookkeeping ----------------
    assign w_req_go    = req_val && req_rdy;
    assign w_resp_go   = dut_resp_val && resp_rdy;
    // A response in the same cycle as a request into an empty FIFO is that
    // request's own response: count it with zero latency, skip the FIFO.
    assign w_bypass    = w_req_go && w_resp_go && w_empty;
    assign w_push      = w_req_go && !w_bypass;
    assign w_pop       = w_resp_go && !w_empty;
    assign w_complete  = w_pop || w_bypass;
    assign w_underflow = w_resp_go && w_empty && !w_req_go;

    // Modular subtraction keeps the latency exact across counter wrap.
    assign w_lat       = w_bypass ? '0 : (r_cyc - r_ts_mem[r_rd_ptr]);
    assign w_total_sum = {1'b0, r_lat_total} + {1'b0, w_lat};

    // Timestamp storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_ts_mem[r_wr_ptr] <= r_cyc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cyc    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            r_cyc <= r_cyc + 1'b1;
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_ptr_last) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // ---------------- statistics ----------------
    // clear takes priority: a completion in the clear cycle still pops the
    // FIFO above but is not accumulated here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_txn_count <= '0;
            r_lat_total <= '0;
            r_lat_min   <= c_cnt_ones;
            r_lat_max   <= '0;
            r_err       <= 1'b0;
        end else if (clear) begin
            r_txn_count <= '0;
            r_lat_total <= '0;
            r_lat_min   <= c_cnt_ones;
            r_lat_max   <= '0;
            r_err       <= 1'b0;
        end else if (w_complete) begin
            if (r_txn_count != c_cnt_ones) begin
                r_txn_count <= r_txn_count + 1'b1;
            end
            r_lat_total <= w_total_sum[CNT_W] ? c_cnt_ones : w_total_sum[CNT_W-1:0];
            if (w_lat < r_lat_min) begin
                r_lat_min <= w_lat;
            end
            if (w_lat > r_lat_max) begin
                r_lat_max <= w_lat;
            end
        end else if (w_underflow) begin
            r_err <= 1'b1;
        end
    end

    assign stat_txn_count = r_txn_count;
    assign stat_lat_total = r_lat_total;
    assign stat_lat_min   = r_lat_min;
    assign stat_lat_max   = r_lat_max;
    assign stat_inflight  = r_occ;
    assign err_underflow  = r_err;

endmodule
`default_nettype wire
